colormap_lut: RTL and testbench
===============================

Name: colormap_lut

Overview:
- Parametrised, runtime-loadable false-colour mapper for the spectrogram display path.
- Holds NMAPS independent RGB palettes in one on-chip table; each palette maps an IW-bit magnitude pixel to three OW-bit colour components.
- After reset every palette is filled with a greyscale ramp. Software can then overwrite any entry and switch palettes on frame boundaries without tearing.
- Sits between the log-magnitude/scroll buffer and the video output stage. Registered, 2-cycle latency, sync/valid passthrough.

Parameters:
- IW, 8, input pixel width; each palette has 2^IW entries.
- OW, 8, width of each colour component.
- NMAPS, 4, number of palettes; must be a power of two, at least 2.
- MW, $clog2(NMAPS), palette index width (derived localparam, not user-set).

Ports:
- i_clk  in  1  system/pixel clock.
- i_reset_n  in  1  synchronous, active-low reset.
- i_valid  in  1  pixel strobe.
- i_pixel  in  IW  magnitude pixel.
- i_frame  in  1  start-of-frame marker, qualified by i_valid.
- i_hsync  in  1  sideband passed through with pixel latency.
- i_vsync  in  1  sideband passed through with pixel latency.
- i_map_sel  in  MW  requested palette.
- i_wr  in  1  table write strobe.
- i_wr_map  in  MW  palette to write.
- i_wr_addr  in  IW  entry to write.
- i_wr_rgb  in  3*OW  {r,g,b} entry data.
- o_ready  out  1  high once the init fill is done; writes accepted only while high.
- o_valid  out  1  output pixel strobe.
- o_r  out  OW  red component.
- o_g  out  OW  green component.
- o_b  out  OW  blue component.
- o_hsync  out  1  delayed i_hsync.
- o_vsync  out  1  delayed i_vsync.
- o_map  out  MW  palette used for the current output pixel.

Behaviour:
- Reset (i_reset_n low at a rising edge):
  - o_ready=0, o_valid=0, o_r/o_g/o_b=0, o_hsync=o_vsync=0, o_map=0.
  - Active palette register=0, fill counter=0, state=INIT.
  - Applies equally mid-fill or mid-frame; the fill restarts from 0.
- State machine has two states, INIT and RUN.
- INIT:
  - Writes one table entry per cycle at linear index cnt={map,addr}, from 0 to NMAPS*2^IW-1.
  - Each entry is a greyscale ramp: r=g=b=top OW bits of addr repeated (bit-replicated) to OW bits. For IW=OW=8 this gives entry k = 8'hkk.
  - After the last index is written, the next cycle enters RUN and o_ready=1. Default fill takes 1024 cycles.
  - i_wr is ignored in INIT.
  - Pixels arriving in INIT still flow through with o_valid/syncs timed as normal, but o_r/o_g/o_b are forced to 0.
- RUN:
  - i_wr writes {i_wr_map,i_wr_addr} with i_wr_rgb in the same cycle.
  - Read and write to the same entry in the same cycle is read-before-write: the pixel sees the old data and the new data is visible from the next read.
- Palette switching:
  - The active palette loads from i_map_sel only on a cycle with i_valid && i_frame.
  - That pixel already uses the new palette.
  - i_map_sel changes at any other time have no effect.
- Pipeline (fixed 2-cycle latency, no stall):
  - Stage 1 registers address={active_or_new_map, i_pixel}, valid, syncs and the INIT flag.
  - Stage 2 performs the registered RAM read and drives o_r/o_g/o_b, o_valid, o_hsync, o_vsync and o_map.
  - When o_valid=0, o_r/o_g/o_b hold their previous values. Consumers must qualify on o_valid.
  - Back-to-back pixels are supported every cycle.

Decomposition:
- Package colormap_pkg:
  - State enum {INIT, RUN}.
  - Greyscale ramp function (addr IW bits -> OW bits, bit replication).
  - Helper for RGB packing order {r[3*OW-1:2*OW], g, b[OW-1:0]}.
- Sub-module colormap_ram:
  - Simple dual-port RAM, depth NMAPS*2^IW, width 3*OW.
  - One write port and one registered read port, read-before-write.
  - The top level muxes the fill counter and the user write port onto its write port.

Test Plan:
- Reset, then count cycles: o_ready rises exactly 1024 cycles after reset release (defaults). A pixel 8'h40 sent during INIT gives o_valid 2 cycles later with rgb=0.
- After o_ready, stream pixels 0..255 on palette 0 -> o_r=o_g=o_b=pixel, each 2 cycles after its input. o_hsync/o_vsync track input delayed by 2.
- Write map 2 addr 8'h80 = 24'hFF0000, set i_map_sel=2 mid-frame, send pixel 8'h80 -> still 808080 on map 0. Then send i_frame with pixel 8'h80 -> FF0000, o_map=2.
- Same-cycle write to map 0 addr 8'h10 (24'h00FF00) and read of pixel 8'h10 -> 101010; the next read of 8'h10 -> 00FF00.
- Assert reset mid-frame after custom writes -> outputs zeroed the next cycle. After the fill, map 2 addr 8'h80 reads 808080 again.
- i_wr during INIT (map 1 addr 5 = 24'h123456) -> ignored; after o_ready, map 1 pixel 5 reads 050505.

Source files
------------

// File: rtl/colormap_pkg.sv
// Shared types and helpers for the false-colour mapper.
// Contents: FSM state enum, greyscale ramp generator, RGB packing helper.
// Widths are passed in explicitly so one package serves any IW/OW build.
package colormap_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Greyscale ramp: the top OW bits of addr, bit-replicated when OW > IW.
  // Output bit (ow-1-j) takes addr bit (iw-1 - j mod iw), so the MSBs of the
  // colour always track the MSBs of the magnitude.
  function automatic logic [31:0] grey_ramp(input logic [31:0] addr,
                                            input int          iw,
                                            input int          ow);
    logic [31:0] res;
    res = '0;
    for (int j = 0; j < ow; j++) begin
      res[ow-1-j] = addr[iw-1-(j%iw)];
    end
    return res;
  endfunction

  // Table word layout: {r, g, b} with r in the top OW bits and b in the bottom.
  function automatic logic [95:0] pack_rgb(input logic [31:0] r,
                                           input logic [31:0] g,
                                           input logic [31:0] b,
                                           input int          ow);
    return ({64'd0, r} << (2*ow)) | ({64'd0, g} << ow) | {64'd0, b};
  endfunction

endpackage

// File: rtl/colormap_ram.sv
// Palette table: simple dual-port RAM, one write port, one registered read port.
// Latency: read data appears one clock after i_re; no backpressure (always accepts).
// A read and a write to the same address on one edge return the old contents.
//
// Ports:
//   i_clk, i_reset_n     clock, synchronous active-low reset (read register only)
//   i_we/i_waddr/i_wdata write port
//   i_re/i_rzero/i_raddr read enable, force-zero for the read word, read address
//   o_rdata              registered read data, held while i_re is low
module colormap_ram #(
  parameter int AW = 10,
  parameter int DW = 24
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic          i_rzero,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  // Storage has no reset: contents are rebuilt by the fill sequence instead.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  // Separate process from the write so the read samples the pre-write value.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      rdata_q <= '0;
    end else if (i_re) begin
      rdata_q <= i_rzero ? '0 : mem_q[i_raddr];
    end
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/colormap_lut.sv
// Runtime-loadable false-colour mapper: IW-bit magnitude -> {r,g,b} via NMAPS palettes.
// Latency: fixed 2 cycles pixel-in to pixel-out, sync/valid delayed to match.
// Backpressure: none; accepts a pixel every cycle, table writes only while o_ready.
//
// Ports:
//   i_clk, i_reset_n               clock, synchronous active-low reset
//   i_valid/i_pixel/i_frame        pixel strobe, magnitude, start-of-frame marker
//   i_hsync/i_vsync                sideband, delayed to o_hsync/o_vsync
//   i_map_sel                      palette taken on a valid start-of-frame pixel
//   i_wr/i_wr_map/i_wr_addr/i_wr_rgb  table write port ({r,g,b} data)
//   o_ready                        init fill complete
//   o_valid/o_r/o_g/o_b/o_map      output pixel, colour and palette used
//   o_hsync/o_vsync                delayed sideband
module colormap_lut
  import colormap_pkg::*;
#(
  parameter  int IW    = 8,
  parameter  int OW    = 8,
  parameter  int NMAPS = 4,
  localparam int MW    = $clog2(NMAPS)
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_valid,
  input  logic [IW-1:0]   i_pixel,
  input  logic            i_frame,
  input  logic            i_hsync,
  input  logic            i_vsync,
  input  logic [MW-1:0]   i_map_sel,
  input  logic            i_wr,
  input  logic [MW-1:0]   i_wr_map,
  input  logic [IW-1:0]   i_wr_addr,
  input  logic [3*OW-1:0] i_wr_rgb,
  output logic            o_ready,
  output logic            o_valid,
  output logic [OW-1:0]   o_r,
  output logic [OW-1:0]   o_g,
  output logic [OW-1:0]   o_b,
  output logic            o_hsync,
  output logic            o_vsync,
  output logic [MW-1:0]   o_map
);

  localparam int AW = MW + IW;
  localparam int DW = 3 * OW;

  // ---------------------------------------------------------------------------
  // Fill / run state machine
  // ---------------------------------------------------------------------------
  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          fill_we;
  logic          ready;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q <= INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:    if (&cnt_q) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  always_comb begin
    fill_we = 1'b0;
    ready   = 1'b0;
    case (state_q)
      INIT:    fill_we = 1'b1;
      RUN:     ready   = 1'b1;
      default: fill_we = 1'b1;
    endcase
  end

  // The counter stops advancing once RUN is reached; its wrap on the last
  // fill cycle is harmless because fill_we drops at the same edge.
  assign cnt_d = fill_we ? cnt_q + AW'(1) : cnt_q;

  // Greyscale ramp word for the entry currently being filled.
  logic [OW-1:0] fill_grey;
  logic [DW-1:0] fill_dat;

  assign fill_grey = OW'(grey_ramp(32'(cnt_q[IW-1:0]), IW, OW));
  assign fill_dat  = DW'(pack_rgb(32'(fill_grey), 32'(fill_grey), 32'(fill_grey), OW));

  // ---------------------------------------------------------------------------
  // Palette selection: only a valid start-of-frame pixel may switch, and that
  // pixel already looks up in the new palette.
  // ---------------------------------------------------------------------------
  logic [MW-1:0] map_q, map_d;

  assign map_d = (i_valid && i_frame) ? i_map_sel : map_q;

  // ---------------------------------------------------------------------------
  // Stage 1 registers. The user write is staged alongside the pixel so it
  // reaches the RAM on the same edge as the read of a pixel presented in the
  // same cycle; the RAM's read-before-write then gives that pixel the old word.
  // ---------------------------------------------------------------------------
  logic          s1_vld_q;
  logic          s1_init_q;
  logic          s1_hs_q;
  logic          s1_vs_q;
  logic [AW-1:0] s1_addr_q;
  logic          wr_vld_q;
  logic [AW-1:0] wr_addr_q;
  logic [DW-1:0] wr_dat_q;
  logic          wr_acc;

  assign wr_acc = i_wr && ready;

  // Stage 2 sideband registers; colour comes from the RAM read register.
  logic          vld_q;
  logic          hs_q;
  logic          vs_q;
  logic [MW-1:0] omap_q;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      cnt_q     <= '0;
      map_q     <= '0;
      s1_vld_q  <= 1'b0;
      s1_init_q <= 1'b0;
      s1_hs_q   <= 1'b0;
      s1_vs_q   <= 1'b0;
      s1_addr_q <= '0;
      wr_vld_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_dat_q  <= '0;
      vld_q     <= 1'b0;
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      omap_q    <= '0;
    end else begin
      cnt_q     <= cnt_d;
      map_q     <= map_d;
      s1_vld_q  <= i_valid;
      s1_init_q <= fill_we;
      s1_hs_q   <= i_hsync;
      s1_vs_q   <= i_vsync;
      s1_addr_q <= {map_d, i_pixel};
      wr_vld_q  <= wr_acc;
      wr_addr_q <= {i_wr_map, i_wr_addr};
      wr_dat_q  <= i_wr_rgb;
      vld_q     <= s1_vld_q;
      hs_q      <= s1_hs_q;
      vs_q      <= s1_vs_q;
      if (s1_vld_q) begin
        omap_q <= s1_addr_q[AW-1:IW];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Table. During INIT the fill owns the write port; a staged user write can
  // only exist once RUN has been reached, so the two never collide.
  // ---------------------------------------------------------------------------
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  assign ram_we    = fill_we | wr_vld_q;
  assign ram_waddr = fill_we ? cnt_q    : wr_addr_q;
  assign ram_wdata = fill_we ? fill_dat : wr_dat_q;

  // Pixels that entered during INIT read as black; invalid slots hold the
  // previous colour.
  colormap_ram #(
    .AW (AW),
    .DW (DW)
  ) u_ram (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_we      (ram_we),
    .i_waddr   (ram_waddr),
    .i_wdata   (ram_wdata),
    .i_re      (s1_vld_q),
    .i_rzero   (s1_init_q),
    .i_raddr   (s1_addr_q),
    .o_rdata   (ram_rdata)
  );

  assign o_ready = ready;
  assign o_valid = vld_q;
  assign o_r     = ram_rdata[3*OW-1:2*OW];
  assign o_g     = ram_rdata[2*OW-1:OW];
  assign o_b     = ram_rdata[OW-1:0];
  assign o_hsync = hs_q;
  assign o_vsync = vs_q;
  assign o_map   = omap_q;

endmodule

// File: tb/tb_colormap_lut.sv
module tb_colormap_lut;

  logic        i_clk;
  logic        i_reset_n;
  logic        i_valid;
  logic [7:0]  i_pixel;
  logic        i_frame;
  logic        i_hsync;
  logic        i_vsync;
  logic [1:0]  i_map_sel;
  logic        i_wr;
  logic [1:0]  i_wr_map;
  logic [7:0]  i_wr_addr;
  logic [23:0] i_wr_rgb;
  logic        o_ready;
  logic        o_valid;
  logic [7:0]  o_r;
  logic [7:0]  o_g;
  logic [7:0]  o_b;
  logic        o_hsync;
  logic        o_vsync;
  logic [1:0]  o_map;

  colormap_lut #(.IW(8), .OW(8), .NMAPS(4)) dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_valid   (i_valid),
    .i_pixel   (i_pixel),
    .i_frame   (i_frame),
    .i_hsync   (i_hsync),
    .i_vsync   (i_vsync),
    .i_map_sel (i_map_sel),
    .i_wr      (i_wr),
    .i_wr_map  (i_wr_map),
    .i_wr_addr (i_wr_addr),
    .i_wr_rgb  (i_wr_rgb),
    .o_ready   (o_ready),
    .o_valid   (o_valid),
    .o_r       (o_r),
    .o_g       (o_g),
    .o_b       (o_b),
    .o_hsync   (o_hsync),
    .o_vsync   (o_vsync),
    .o_map     (o_map)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [23:0] rgb;
    logic [1:0]  map;
    logic        hs;
    logic        vs;
    logic [31:0] due;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   chk_cnt;
  int   pass_cnt;

  // Drive one cycle of pixel inputs, record the expected output (due two
  // edges later), advance one clock and settle past the edge.
  task automatic step(input logic v, input logic [7:0] px, input logic fr,
                      input logic [1:0] sel, input logic h, input logic vsy,
                      input logic [23:0] exp_rgb, input logic [1:0] exp_map);
    exp_t e;
    i_valid   = v;
    i_pixel   = px;
    i_frame   = fr;
    i_map_sel = sel;
    i_hsync   = h;
    i_vsync   = vsy;
    if (v) begin
      e.rgb = exp_rgb;
      e.map = exp_map;
      e.hs  = h;
      e.vs  = vsy;
      e.due = 32'(cyc + 2);
      sb.push_back(e);
    end
    @(posedge i_clk);
    #1;
    cyc++;
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 24'h0, 2'd0);
  endtask

  // Pop the scoreboard when the DUT presents a pixel.
  // st: 0 = nothing, 1 = popped into e, 2 = output with nothing expected.
  task automatic observe(output int st, output exp_t e);
    st = 0;
    e  = '0;
    if (o_valid === 1'b1) begin
      if (sb.size() == 0) begin
        st = 2;
      end else begin
        e  = sb.pop_front();
        st = 1;
      end
    end
  endtask

  task automatic test_reset();
    int   st;
    exp_t e;
    int   rel;
    int   ready_at;
    i_reset_n = 1'b0;
    repeat (3) idle();
    chk_cnt++;
    if ({o_ready, o_valid, o_r, o_g, o_b, o_map, o_hsync, o_vsync} !== 30'd0)
      $display("FAIL reset_state: got ready=%b valid=%b rgb=%h map=%0d hs=%b vs=%b required all zero",
               o_ready, o_valid, {o_r, o_g, o_b}, o_map, o_hsync, o_vsync);
    else pass_cnt++;

    i_reset_n = 1'b1;
    rel       = cyc;
    ready_at  = -1;
    for (int i = 0; i < 1100 && (ready_at < 0 || sb.size() != 0); i++) begin
      if (i == 4) step(1'b1, 8'h40, 1'b0, 2'd0, 1'b1, 1'b1, 24'h000000, 2'd0);
      else        idle();
      observe(st, e);
      if (st == 2) begin
        chk_cnt++;
        $display("FAIL init_pixel spurious: got o_valid=1 required 0");
      end else if (st == 1) begin
        chk_cnt++;
        if ({o_r, o_g, o_b, o_map, o_hsync, o_vsync} !== {e.rgb, e.map, e.hs, e.vs} || cyc != int'(e.due))
          $display("FAIL init_pixel: got rgb=%h map=%0d hs=%b vs=%b cyc=%0d required rgb=%h map=%0d hs=%b vs=%b cyc=%0d",
                   {o_r, o_g, o_b}, o_map, o_hsync, o_vsync, cyc, e.rgb, e.map, e.hs, e.vs, e.due);
        else pass_cnt++;
      end
      if (o_ready === 1'b1 && ready_at < 0) ready_at = cyc - rel;
    end
    chk_cnt++;
    if (ready_at != 1024) $display("FAIL ready_latency: got %0d required 1024", ready_at);
    else pass_cnt++;
    chk_cnt++;
    if (sb.size() != 0) $display("FAIL init_pixel missing: got %0d pending required 0", sb.size());
    else pass_cnt++;
  endtask

  task automatic test_ramp();
    int   st;
    exp_t e;
    for (int i = 0; i < 259; i++) begin
      if (i < 256) step(1'b1, 8'(i), i == 0, 2'd0, i[0], i == 0, {3{8'(i)}}, 2'd0);
      else         idle();
      observe(st, e);
      if (st == 2) begin
        chk_cnt++;
        $display("FAIL ramp spurious: got o_valid=1 required 0");
      end else if (st == 1) begin
        chk_cnt++;
        if ({o_r, o_g, o_b, o_map, o_hsync, o_vsync} !== {e.rgb, e.map, e.hs, e.vs} || cyc != int'(e.due))
          $display("FAIL ramp: got rgb=%h map=%0d hs=%b vs=%b cyc=%0d required rgb=%h map=%0d hs=%b vs=%b cyc=%0d",
                   {o_r, o_g, o_b}, o_map, o_hsync, o_vsync, cyc, e.rgb, e.map, e.hs, e.vs, e.due);
        else pass_cnt++;
      end
    end
    chk_cnt++;
    if (sb.size() != 0) $display("FAIL ramp missing: got %0d pending required 0", sb.size());
    else pass_cnt++;
  endtask

  task automatic test_switch();
    int   st;
    exp_t e;
    for (int i = 0; i < 7; i++) begin
      case (i)
        0: begin
          i_wr = 1'b1; i_wr_map = 2'd2; i_wr_addr = 8'h80; i_wr_rgb = 24'hFF0000;
          idle();
          i_wr = 1'b0;
        end
        1: step(1'b1, 8'h80, 1'b0, 2'd2, 1'b0, 1'b0, 24'h808080, 2'd0);
        2: step(1'b1, 8'h80, 1'b1, 2'd2, 1'b1, 1'b0, 24'hFF0000, 2'd2);
        3: step(1'b1, 8'h80, 1'b0, 2'd0, 1'b0, 1'b1, 24'hFF0000, 2'd2);
        default: idle();
      endcase
      observe(st, e);
      if (st == 2) begin
        chk_cnt++;
        $display("FAIL switch spurious: got o_valid=1 required 0");
      end else if (st == 1) begin
        chk_cnt++;
        if ({o_r, o_g, o_b, o_map, o_hsync, o_vsync} !== {e.rgb, e.map, e.hs, e.vs} || cyc != int'(e.due))
          $display("FAIL switch: got rgb=%h map=%0d hs=%b vs=%b cyc=%0d required rgb=%h map=%0d hs=%b vs=%b cyc=%0d",
                   {o_r, o_g, o_b}, o_map, o_hsync, o_vsync, cyc, e.rgb, e.map, e.hs, e.vs, e.due);
        else pass_cnt++;
      end
    end
    chk_cnt++;
    if (sb.size() != 0) $display("FAIL switch missing: got %0d pending required 0", sb.size());
    else pass_cnt++;
  endtask

  task automatic test_rbw();
    int   st;
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: step(1'b1, 8'h10, 1'b1, 2'd0, 1'b0, 1'b0, 24'h101010, 2'd0);
        1: begin
          i_wr = 1'b1; i_wr_map = 2'd0; i_wr_addr = 8'h10; i_wr_rgb = 24'h00FF00;
          step(1'b1, 8'h10, 1'b0, 2'd0, 1'b1, 1'b1, 24'h101010, 2'd0);
          i_wr = 1'b0;
        end
        2: step(1'b1, 8'h10, 1'b0, 2'd0, 1'b0, 1'b0, 24'h00FF00, 2'd0);
        default: idle();
      endcase
      observe(st, e);
      if (st == 2) begin
        chk_cnt++;
        $display("FAIL rbw spurious: got o_valid=1 required 0");
      end else if (st == 1) begin
        chk_cnt++;
        if ({o_r, o_g, o_b, o_map, o_hsync, o_vsync} !== {e.rgb, e.map, e.hs, e.vs} || cyc != int'(e.due))
          $display("FAIL rbw: got rgb=%h map=%0d hs=%b vs=%b cyc=%0d required rgb=%h map=%0d hs=%b vs=%b cyc=%0d",
                   {o_r, o_g, o_b}, o_map, o_hsync, o_vsync, cyc, e.rgb, e.map, e.hs, e.vs, e.due);
        else pass_cnt++;
      end
    end
    chk_cnt++;
    if (sb.size() != 0) $display("FAIL rbw missing: got %0d pending required 0", sb.size());
    else pass_cnt++;
    // With no valid pixels the colour must hold the last value.
    chk_cnt++;
    if (o_valid !== 1'b0 || {o_r, o_g, o_b} !== 24'h00FF00)
      $display("FAIL hold: got valid=%b rgb=%h required valid=0 rgb=00ff00", o_valid, {o_r, o_g, o_b});
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int   st;
    exp_t e;
    int   rel;
    int   ready_at;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: step(1'b1, 8'h80, 1'b1, 2'd2, 1'b0, 1'b0, 24'hFF0000, 2'd2);
        1: step(1'b1, 8'h11, 1'b0, 2'd2, 1'b1, 1'b1, 24'h111111, 2'd2);
        default: begin
          i_reset_n = 1'b0;
          step(1'b0, 8'h00, 1'b0, 2'd2, 1'b1, 1'b1, 24'h0, 2'd0);
        end
      endcase
      observe(st, e);
      if (st == 2) begin
        chk_cnt++;
        $display("FAIL pre_reset spurious: got o_valid=1 required 0");
      end else if (st == 1) begin
        chk_cnt++;
        if ({o_r, o_g, o_b, o_map, o_hsync, o_vsync} !== {e.rgb, e.map, e.hs, e.vs} || cyc != int'(e.due))
          $display("FAIL pre_reset: got rgb=%h map=%0d hs=%b vs=%b cyc=%0d required rgb=%h map=%0d hs=%b vs=%b cyc=%0d",
                   {o_r, o_g, o_b}, o_map, o_hsync, o_vsync, cyc, e.rgb, e.map, e.hs, e.vs, e.due);
        else pass_cnt++;
      end
    end
    // The in-flight 0x11 pixel is discarded by the reset.
    sb.delete();
    chk_cnt++;
    if ({o_ready, o_valid, o_r, o_g, o_b, o_map, o_hsync, o_vsync} !== 30'd0)
      $display("FAIL mid_reset_state: got ready=%b valid=%b rgb=%h map=%0d hs=%b vs=%b required all zero",
               o_ready, o_valid, {o_r, o_g, o_b}, o_map, o_hsync, o_vsync);
    else pass_cnt++;

    i_reset_n = 1'b1;
    rel       = cyc;
    ready_at  = -1;
    for (int i = 0; i < 1100 && ready_at < 0; i++) begin
      if (i < 3) begin
        i_wr = 1'b1; i_wr_map = 2'd1; i_wr_addr = 8'h05; i_wr_rgb = 24'h123456;
      end else begin
        i_wr = 1'b0;
      end
      idle();
      observe(st, e);
      if (st != 0) begin
        chk_cnt++;
        $display("FAIL refill spurious: got o_valid=1 required 0");
      end
      if (o_ready === 1'b1) ready_at = cyc - rel;
    end
    i_wr = 1'b0;
    chk_cnt++;
    if (ready_at != 1024) $display("FAIL refill_latency: got %0d required 1024", ready_at);
    else pass_cnt++;

    for (int i = 0; i < 7; i++) begin
      case (i)
        0: step(1'b1, 8'h80, 1'b0, 2'd3, 1'b0, 1'b1, 24'h808080, 2'd0);
        1: step(1'b1, 8'h80, 1'b1, 2'd2, 1'b1, 1'b0, 24'h808080, 2'd2);
        2: step(1'b1, 8'h05, 1'b1, 2'd1, 1'b0, 1'b0, 24'h050505, 2'd1);
        3: step(1'b1, 8'h10, 1'b1, 2'd0, 1'b1, 1'b1, 24'h101010, 2'd0);
        default: idle();
      endcase
      observe(st, e);
      if (st == 2) begin
        chk_cnt++;
        $display("FAIL post_reset spurious: got o_valid=1 required 0");
      end else if (st == 1) begin
        chk_cnt++;
        if ({o_r, o_g, o_b, o_map, o_hsync, o_vsync} !== {e.rgb, e.map, e.hs, e.vs} || cyc != int'(e.due))
          $display("FAIL post_reset: got rgb=%h map=%0d hs=%b vs=%b cyc=%0d required rgb=%h map=%0d hs=%b vs=%b cyc=%0d",
                   {o_r, o_g, o_b}, o_map, o_hsync, o_vsync, cyc, e.rgb, e.map, e.hs, e.vs, e.due);
        else pass_cnt++;
      end
    end
    chk_cnt++;
    if (sb.size() != 0) $display("FAIL post_reset missing: got %0d pending required 0", sb.size());
    else pass_cnt++;
  endtask

  initial begin
    cyc       = 0;
    chk_cnt   = 0;
    pass_cnt  = 0;
    i_reset_n = 1'b0;
    i_valid   = 1'b0;
    i_pixel   = 8'h00;
    i_frame   = 1'b0;
    i_hsync   = 1'b0;
    i_vsync   = 1'b0;
    i_map_sel = 2'd0;
    i_wr      = 1'b0;
    i_wr_map  = 2'd0;
    i_wr_addr = 8'h00;
    i_wr_rgb  = 24'h0;
    #2;
    test_reset();
    test_ramp();
    test_switch();
    test_rbw();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: got no completion within 1000000 time units required completion");
    $fatal(1, "timeout");
  end

endmodule
